// File: rtl/alu_control_muldiv_pkg.sv
// Shared encodings for the EX-stage ALU control: ALU operation codes, funct values,
// the mul/div sequencer state and the engine operation selector.
package alu_control_muldiv_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;

    function automatic muldiv_op_t funct_to_mdop(input logic [5:0] f);
        case (f)
            FUNC_MULTU: return MD_MULTU;
            FUNC_DIV:   return MD_DIV;
            FUNC_DIVU:  return MD_DIVU;
            default:    return MD_MULT;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_muldiv_engine.sv
// Radix-2 multiply/divide datapath: shift-add multiply and restoring divide on operand
// magnitudes, with the sign fix-up applied to the final-step result.
module alu_control_muldiv_engine
    import alu_control_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_p;
    logic               neg_r;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     acc_hi_n;
    logic [WIDTH-1:0]   acc_lo_n;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic               sgn;
    logic               div_op;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic s);
        return (s && v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    assign sgn    = (op == MD_MULT) || (op == MD_DIV);
    assign div_op = (op == MD_DIV) || (op == MD_DIVU);
    assign done   = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (start)
            count <= CW'(WIDTH);
        else if (count != '0)
            count <= count - CW'(1);
    end

    // operand latch / iteration stage
    always_ff @(posedge clk) begin
        if (start) begin
            is_div  <= div_op;
            neg_p   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r   <= sgn && a[WIDTH-1];
            divisor <= mag($signed(b), sgn);
            acc_hi  <= '0;
            acc_lo  <= mag($signed(a), sgn);
        end else if (count != '0) begin
            acc_hi  <= acc_hi_n;
            acc_lo  <= acc_lo_n;
        end
    end

    always_comb begin
        shifted  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        sum      = acc_hi + (acc_lo[0] ? {1'b0, divisor} : '0);
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        if (is_div) begin
            // a borrow out of the trial subtraction means the divisor did not fit
            if (trial[WIDTH]) begin
                acc_hi_n = shifted;
                acc_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                acc_hi_n = trial;
                acc_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_hi_n = {1'b0, sum[WIDTH:1]};
            acc_lo_n = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = {acc_hi_n[WIDTH-1:0], acc_lo_n};
        prod_s = neg_p ? neg_2w(prod) : prod;
        if (is_div) begin
            lo = neg_p ? neg_w(acc_lo_n) : acc_lo_n;
            hi = neg_r ? neg_w(acc_hi_n[WIDTH-1:0]) : acc_hi_n[WIDTH-1:0];
        end else begin
            lo = prod_s[WIDTH-1:0];
            hi = prod_s[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control: aluOp/funct decode, HI/LO registers and the mul/div sequencer
// that stalls the pipeline while the iterative engine runs.
module alu_control_muldiv
    import alu_control_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit DIV_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [3:0]       operation,
    output logic             useHiLo,
    output logic [WIDTH-1:0] hiLoOut,
    output logic             stall
);

    muldiv_state_t    state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             rtype;
    logic             is_mul;
    logic             is_div;
    logic             start;
    logic             div_zero;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    muldiv_op_t       md_op;

    assign rtype     = valid && (aluOp == ALUOP_RTYPE);
    assign is_mul    = (funct == FUNC_MULT) || (funct == FUNC_MULTU);
    assign is_div    = DIV_ENABLE && ((funct == FUNC_DIV) || (funct == FUNC_DIVU));
    assign start     = rtype && (is_mul || is_div) && (state == IDLE);
    assign div_zero  = is_div && (srcB == '0);
    assign eng_start = start && !div_zero;
    assign md_op     = funct_to_mdop(funct);
    assign stall     = !reset && (start || (state == RUN));
    assign useHiLo   = rtype && ((funct == FUNC_MFHI) || (funct == FUNC_MFLO));
    assign hiLoOut   = !useHiLo ? '0 : ((funct == FUNC_MFHI) ? hi : lo);

    always_comb begin
        operation = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNC_SUB, FUNC_SUBU: operation = ALU_SUB;
                    FUNC_AND:            operation = ALU_AND;
                    FUNC_OR:             operation = ALU_OR;
                    FUNC_XOR:            operation = ALU_XOR;
                    FUNC_NOR:            operation = ALU_NOR;
                    FUNC_SLT:            operation = ALU_SLT;
                    FUNC_SLTU:           operation = ALU_SLTU;
                    default:             operation = ALU_ADD;
                endcase
            end
            default: operation = ALU_ADD;
        endcase
    end

    alu_control_muldiv_engine #(.WIDTH(WIDTH)) u_engine (
        .clk   (clk),
        .rst   (reset),
        .start (eng_start),
        .op    (md_op),
        .a     (srcA),
        .b     (srcB),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    // DONE lets the held instruction retire without restarting it
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            hi    <= srcA;
                            lo    <= '1;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end else if (rtype && funct == FUNC_MTHI) begin
                        hi <= srcA;
                    end else if (rtype && funct == FUNC_MTLO) begin
                        lo <= srcA;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        hi    <= eng_hi;
                        lo    <= eng_lo;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed and randomized bench for alu_control_muldiv with an arithmetic reference model.
module tb_alu_control_muldiv;
    import alu_control_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  aluOp;
    logic [5:0]  funct;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  operation;
    logic        useHiLo;
    logic [31:0] hiLoOut;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    alu_control_muldiv #(.WIDTH(32), .DIV_ENABLE(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .aluOp     (aluOp),
        .funct     (funct),
        .srcA      (srcA),
        .srcB      (srcB),
        .operation (operation),
        .useHiLo   (useHiLo),
        .hiLoOut   (hiLoOut),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_op(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return ALU_SUB;
        if (op != 2'b10) return ALU_ADD;
        case (f)
            6'h22, 6'h23: return ALU_SUB;
            6'h24:        return ALU_AND;
            6'h25:        return ALU_OR;
            6'h26:        return ALU_XOR;
            6'h27:        return ALU_NOR;
            6'h2A:        return ALU_SLT;
            6'h2B:        return ALU_SLTU;
            default:      return ALU_ADD;
        endcase
    endfunction

    // Reference arithmetic: 64-bit integer math, C-style truncating division
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            6'h19: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    if (f == 6'h1B) begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
        endcase
    endtask

    // Issues a mul/div at the start of a cycle and counts the stall cycles seen
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stalls, input bit hold, input string tag);
        int n;
        model(f, a, b);
        valid = 1'b1; aluOp = 2'b10; funct = f; srcA = a; srcB = b;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            cyc();
        end
        chk(tag, 64'(n), 64'(exp_stalls));
        cyc();
        if (!hold) valid = 1'b0;
    endtask

    task automatic read_hilo(input logic [31:0] eh, input logic [31:0] el, input string tag);
        valid = 1'b1; aluOp = 2'b10; funct = FUNC_MFHI;
        @(negedge clk);
        chk({tag, "_mfhi"}, 64'(hiLoOut), 64'(eh));
        chk({tag, "_usehilo"}, 64'(useHiLo), 64'd1);
        chk({tag, "_mf_stall"}, 64'(stall), 64'd0);
        cyc();
        funct = FUNC_MFLO;
        @(negedge clk);
        chk({tag, "_mflo"}, 64'(hiLoOut), 64'(el));
        cyc();
        valid = 1'b0;
    endtask

    task automatic move_to(input logic [5:0] f, input logic [31:0] a, input string tag);
        valid = 1'b1; aluOp = 2'b10; funct = f; srcA = a; srcB = $urandom;
        @(negedge clk);
        chk(tag, 64'(stall), 64'd0);
        cyc();
        valid = 1'b0;
        if (f == FUNC_MTHI) m_hi = a; else m_lo = a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [5:0]  f;
        int          kind;
        int          s;

        reset = 1'b1; valid = 1'b0; aluOp = 2'b00; funct = 6'h00; srcA = '0; srcB = '0;
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        cyc();
        cyc();
        reset = 1'b0;
        read_hilo(32'h0, 32'h0, "reset_hilo");

        // Decode sweep (valid low so nothing starts)
        for (int i = 0; i < 64; i++) begin
            valid = 1'b0; aluOp = 2'b10; funct = 6'(i);
            @(negedge clk);
            chk("decode_rtype", 64'(operation), 64'(exp_op(2'b10, 6'(i))));
            chk("decode_usehilo_invalid", 64'(useHiLo), 64'd0);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) continue;
            aluOp = 2'(i); funct = 6'(FUNC_SUB);
            @(negedge clk);
            chk("decode_aluop", 64'(operation), 64'(exp_op(2'(i), FUNC_SUB)));
            cyc();
        end
        valid = 1'b1; aluOp = 2'b10; funct = FUNC_ADD;
        @(negedge clk);
        chk("hilo_out_zero", 64'(hiLoOut), 64'd0);
        chk("hilo_use_zero", 64'(useHiLo), 64'd0);
        cyc();
        valid = 1'b0;

        run_md(FUNC_MULT, 32'hFFFF_FFFD, 32'd7, 33, 1'b0, "mult_neg_stalls");
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");

        run_md(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, "multu_max_stalls");
        read_hilo(32'hFFFF_FFFE, 32'h0000_0001, "multu_max");

        run_md(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 33, 1'b0, "div_neg_stalls");
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");

        run_md(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, "div_ovf_stalls");
        read_hilo(32'h0, 32'h8000_0000, "div_ovf");

        run_md(FUNC_DIVU, 32'd5, 32'd0, 1, 1'b0, "divu_zero_stalls");
        read_hilo(32'd5, 32'hFFFF_FFFF, "divu_zero");

        move_to(FUNC_MTHI, 32'h1234, "mthi_stall");
        read_hilo(32'h1234, 32'hFFFF_FFFF, "mthi");

        run_md(FUNC_MULT, 32'd4, 32'd5, 33, 1'b1, "b2b_first_stalls");
        run_md(FUNC_MULT, 32'd4, 32'd5, 33, 1'b0, "b2b_second_stalls");
        read_hilo(32'h0, 32'd20, "b2b");

        // Reset in RUN cycle 10 aborts the operation
        valid = 1'b1; aluOp = 2'b10; funct = FUNC_MULT; srcA = 32'd9; srcB = 32'd9;
        repeat (10) cyc();
        @(negedge clk);
        chk("run10_stall", 64'(stall), 64'd1);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_cycle_stall", 64'(stall), 64'd0);
        cyc();
        reset = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", 64'(stall), 64'd0);
        cyc();
        read_hilo(32'h0, 32'h0, "post_reset");
        run_md(FUNC_MULT, 32'd2, 32'd3, 33, 1'b0, "fresh_mult_stalls");
        read_hilo(32'h0, 32'd6, "fresh_mult");

        // Randomized mix against the arithmetic model
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 5));
            a = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else begin
                s = int'($urandom_range(0, 18)) - 9;
                b = 32'(s);
            end
            case (kind)
                0: f = FUNC_MULT;
                1: f = FUNC_MULTU;
                2: f = FUNC_DIV;
                3: f = FUNC_DIVU;
                4: f = FUNC_MTHI;
                default: f = FUNC_MTLO;
            endcase
            if (kind < 4) begin
                run_md(f, a, b, ((kind >= 2) && (b == 32'd0)) ? 1 : 33, 1'b0, "rnd_stalls");
                read_hilo(m_hi, m_lo, "rnd");
            end else begin
                move_to(f, a, "rnd_mt_stall");
                read_hilo(m_hi, m_lo, "rnd_mt");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
